// File: rtl/aznable_ioctl_pkg.sv
// Shared definitions for the ioctl upload path.
//   - upload_state_e : controller FSM states
//   - IDX_*          : hps_io transfer index assignments
//   - TIMEOUT_DEFAULT: default cycles to wait for the HPS to accept a request
//   - OOR_FILL       : byte returned for addresses outside the RAM
//   - BYTE_COUNT_MAX : saturation value of the served-read counter
package aznable_ioctl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } upload_state_e;

    localparam logic [7:0]  IDX_BIOS        = 8'd0;
    localparam logic [7:0]  IDX_SPRITE      = 8'd3;
    localparam logic [7:0]  IDX_SAVE        = 8'd4;

    localparam logic [23:0] TIMEOUT_DEFAULT = 24'hFFFFFF;
    localparam logic [7:0]  OOR_FILL        = 8'hFF;
    localparam logic [16:0] BYTE_COUNT_MAX  = 17'h1FFFF;

endpackage

// File: rtl/ioctl_upload_ctrl_if.sv
// hps_io upload-side signal bundle.
//   master : the hps_io side (drives upload/index/rd/addr, receives din/req)
//   slave  : the upload controller (receives upload/index/rd/addr, drives din/req)
interface ioctl_upload_ctrl_if;

    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_upload_req
    );

endinterface

// File: rtl/ioctl_upload_ctrl_upload_fetch.sv
// upload_fetch: three-stage byte fetch for hps_io reads.
//   Cycle N   : rd accepted (enable high, nothing in flight)
//   Cycle N+1 : mem_addr/mem_rd presented to the registered RAM
//   Cycle N+2 : RAM data (or OOR_FILL) loaded into din at the closing edge
//   Cycle N+3 : din valid; it then holds until the next fetch completes
// Ports: clk_sys/reset, enable (controller is ACTIVE), overrun_clr, rd/addr
// from hps_io, mem_dout from RAM; outputs mem_addr/mem_rd, din, overrun_err,
// accept (a read was taken this cycle), pending (a read still has to reach
// the RAM stage).
module upload_fetch
    import aznable_ioctl_pkg::*;
#(
    parameter logic [16:0] MEM_BYTES = 17'd65536
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        enable,
    input  logic        overrun_clr,
    input  logic        rd,
    input  logic [24:0] addr,
    input  logic [7:0]  mem_dout,
    output logic [16:0] mem_addr,
    output logic        mem_rd,
    output logic [7:0]  din,
    output logic        overrun_err,
    output logic        accept,
    output logic        pending
);

    logic        stage1_r;
    logic        stage1_oor_r;
    logic        stage2_r;
    logic        stage2_oor_r;
    logic        mem_rd_r;
    logic [16:0] mem_addr_r;
    logic [7:0]  din_r;
    logic        overrun_r;

    logic        inflight_s;
    logic        in_range_s;
    logic        accept_s;

    // A full 25-bit compare covers both the upper-bit and the MEM_BYTES limit.
    assign in_range_s = (addr < {8'd0, MEM_BYTES});
    assign inflight_s = stage1_r | stage2_r;
    assign accept_s   = enable & rd & ~inflight_s;

    // Stage 1: capture the request and strobe the RAM only for in-range bytes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stage1_r     <= 1'b0;
            stage1_oor_r <= 1'b0;
            mem_rd_r     <= 1'b0;
            mem_addr_r   <= 17'd0;
        end else if (accept_s) begin
            stage1_r     <= 1'b1;
            stage1_oor_r <= ~in_range_s;
            mem_rd_r     <= in_range_s;
            mem_addr_r   <= addr[16:0];
        end else begin
            stage1_r     <= 1'b0;
            stage1_oor_r <= 1'b0;
            mem_rd_r     <= 1'b0;
            mem_addr_r   <= mem_addr_r;
        end
    end

    // Stage 2: wait for the registered RAM output to become valid.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stage2_r     <= 1'b0;
            stage2_oor_r <= 1'b0;
        end else begin
            stage2_r     <= stage1_r;
            stage2_oor_r <= stage1_oor_r;
        end
    end

    // Stage 3: load the returned byte, substituting the fill for bad addresses.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            din_r <= 8'd0;
        end else if (stage2_r) begin
            din_r <= stage2_oor_r ? OOR_FILL : mem_dout;
        end else begin
            din_r <= din_r;
        end
    end

    // Sticky overrun flag: a read arrived while a fetch was still in flight.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end else if (rd & inflight_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign mem_addr    = mem_addr_r;
    assign mem_rd      = mem_rd_r;
    assign din         = din_r;
    assign overrun_err = overrun_r;
    assign accept      = accept_s;
    assign pending     = accept_s | stage1_r;

endmodule

// File: rtl/ioctl_upload_ctrl.sv
// ioctl_upload_ctrl: serves hps_io upload reads from an external RAM.
// A core save_trigger raises ioctl_upload_req until the HPS starts an upload
// with our index (or the request times out); an HPS-initiated upload with our
// index is served directly. Each hps_io read is fetched by upload_fetch.
// Ports: clk_sys, reset (sync, active high), save_trigger, hps (hps_io bundle,
// slave side), mem_addr/mem_rd/mem_dout (registered-read RAM), busy, done,
// timeout_err, overrun_err, byte_count.
module ioctl_upload_ctrl
    import aznable_ioctl_pkg::*;
#(
    parameter logic [7:0]  UPLOAD_INDEX = IDX_SAVE,
    parameter logic [16:0] MEM_BYTES    = 17'd65536,
    parameter logic [23:0] TIMEOUT      = TIMEOUT_DEFAULT
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                save_trigger,
    ioctl_upload_ctrl_if.slave  hps,
    output logic [16:0]         mem_addr,
    output logic                mem_rd,
    input  logic [7:0]          mem_dout,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic                overrun_err,
    output logic [16:0]         byte_count
);

    upload_state_e state_r;
    upload_state_e state_next_s;

    logic [23:0] tmo_cnt_r;
    logic        req_r;
    logic        busy_r;
    logic        done_r;
    logic        timeout_err_r;
    logic [16:0] byte_count_r;

    logic        index_match_s;
    logic        upload_ours_s;
    logic        tmo_hit_s;
    logic        enter_active_s;
    logic        enter_request_s;
    logic        fetch_enable_s;
    logic        fetch_accept_s;
    logic        fetch_pending_s;
    logic [7:0]  fetch_din_s;

    assign index_match_s   = (hps.ioctl_index == UPLOAD_INDEX);
    assign upload_ours_s   = hps.ioctl_upload & index_match_s;
    assign tmo_hit_s       = (tmo_cnt_r == (TIMEOUT - 24'd1));
    assign enter_active_s  = (state_r != ACTIVE) && (state_next_s == ACTIVE);
    assign enter_request_s = (state_r == IDLE) && (state_next_s == REQUEST);
    assign fetch_enable_s  = (state_r == ACTIVE);

    // FSM state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                // An upload already running for us wins over a coincident trigger.
                if (upload_ours_s) begin
                    state_next_s = ACTIVE;
                end else if (save_trigger && !hps.ioctl_upload) begin
                    state_next_s = REQUEST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQUEST: begin
                if (upload_ours_s) begin
                    state_next_s = ACTIVE;
                end else if (tmo_hit_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REQUEST;
                end
            end
            ACTIVE: begin
                // Hold off DONE until the last read has reached the RAM stage,
                // so the byte is loaded by the time done pulses.
                if (!hps.ioctl_upload) begin
                    if (fetch_pending_s) begin
                        state_next_s = ACTIVE;
                    end else begin
                        state_next_s = DONE;
                    end
                end else if (!index_match_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Registered status outputs decoded from the next state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            req_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            req_r  <= (state_next_s == REQUEST);
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_next_s == DONE);
        end
    end

    // Request timeout counter, restarted on every new request.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tmo_cnt_r <= 24'd0;
        end else if (enter_request_s) begin
            tmo_cnt_r <= 24'd0;
        end else if (state_r == REQUEST) begin
            tmo_cnt_r <= tmo_cnt_r + 24'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Sticky timeout flag; only an accepted new trigger clears it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            timeout_err_r <= 1'b0;
        end else if (enter_request_s) begin
            timeout_err_r <= 1'b0;
        end else if ((state_r == REQUEST) && (state_next_s == IDLE)) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    // Served-read counter, saturating, restarted on each upload.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            byte_count_r <= 17'd0;
        end else if (enter_active_s) begin
            byte_count_r <= 17'd0;
        end else if (fetch_accept_s && (byte_count_r != BYTE_COUNT_MAX)) begin
            byte_count_r <= byte_count_r + 17'd1;
        end else begin
            byte_count_r <= byte_count_r;
        end
    end

    upload_fetch #(
        .MEM_BYTES (MEM_BYTES)
    ) u_fetch (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .enable      (fetch_enable_s),
        .overrun_clr (enter_active_s),
        .rd          (hps.ioctl_rd),
        .addr        (hps.ioctl_addr),
        .mem_dout    (mem_dout),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .din         (fetch_din_s),
        .overrun_err (overrun_err),
        .accept      (fetch_accept_s),
        .pending     (fetch_pending_s)
    );

    assign hps.ioctl_din        = fetch_din_s;
    assign hps.ioctl_upload_req = req_r;
    assign busy                 = busy_r;
    assign done                 = done_r;
    assign timeout_err          = timeout_err_r;
    assign byte_count           = byte_count_r;

endmodule

// File: tb/tb_ioctl_upload_ctrl.sv
// Self-checking bench for ioctl_upload_ctrl (TIMEOUT reduced to 100 cycles).
// Expected read data is queued when a read is issued and compared against
// ioctl_din three cycles later by a monitor.
module tb_ioctl_upload_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        save_trigger;
    logic [7:0]  mem_dout = 8'd0;
    logic [16:0] mem_addr;
    logic        mem_rd;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        overrun_err;
    logic [16:0] byte_count;

    ioctl_upload_ctrl_if hps_if();

    ioctl_upload_ctrl #(
        .UPLOAD_INDEX (8'd4),
        .MEM_BYTES    (17'd65536),
        .TIMEOUT      (24'd100)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .save_trigger (save_trigger),
        .hps          (hps_if),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_dout     (mem_dout),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err),
        .overrun_err  (overrun_err),
        .byte_count   (byte_count)
    );

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    logic [7:0] ram [0:131071];
    exp_t       sb_q[$];
    exp_t       mon_e;
    int         cyc    = 0;
    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         exp_bc = 0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Registered-read RAM model.
    always @(posedge clk_sys) begin
        if (mem_rd) mem_dout <= ram[mem_addr];
    end

    // Scoreboard monitor: each queued byte must be on ioctl_din in its due cycle.
    always @(negedge clk_sys) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (hps_if.ioctl_din !== mon_e.data) begin
                n_bad++;
                $display("FAIL din_sb: got %h want %h (cycle %0d)", hps_if.ioctl_din, mon_e.data, cyc);
            end
        end
    end

    function automatic logic [7:0] ref_byte(input logic [24:0] a);
        if (a < 25'd65536) return ram[a[16:0]];
        else return 8'hFF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // One-cycle read pulse; returns one cycle later with rd low again.
    task automatic issue_rd(input logic [24:0] a);
        exp_t e;
        tick(1);
        hps_if.ioctl_rd   = 1'b1;
        hps_if.ioctl_addr = a;
        e.due  = cyc + 3;
        e.data = ref_byte(a);
        sb_q.push_back(e);
        tick(1);
        hps_if.ioctl_rd = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        @(negedge clk_sys);
        n_cmp++; if ({busy, done, mem_rd, hps_if.ioctl_upload_req} !== 4'b0000) begin n_bad++; $display("FAIL rst_ctrl: busy/done/mem_rd/req=%b want 0000", {busy, done, mem_rd, hps_if.ioctl_upload_req}); end
        n_cmp++; if ({timeout_err, overrun_err} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {timeout_err, overrun_err}); end
        n_cmp++; if (hps_if.ioctl_din !== 8'h00) begin n_bad++; $display("FAIL rst_din: got %h want 00", hps_if.ioctl_din); end
        n_cmp++; if (byte_count !== 17'd0) begin n_bad++; $display("FAIL rst_bc: got %0d want 0", byte_count); end
        reset = 1'b0;
    endtask

    task automatic test_core_request;
        tick(1);
        save_trigger = 1'b1;
        tick(1);
        save_trigger = 1'b0;
        @(negedge clk_sys);
        n_cmp++; if (hps_if.ioctl_upload_req !== 1'b1) begin n_bad++; $display("FAIL req_set: got %b want 1", hps_if.ioctl_upload_req); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL req_busy: got %b want 1", busy); end
        hps_if.ioctl_index  = 8'd4;
        hps_if.ioctl_upload = 1'b1;
        tick(1);
        exp_bc = 0;
        @(negedge clk_sys);
        n_cmp++; if (hps_if.ioctl_upload_req !== 1'b0) begin n_bad++; $display("FAIL req_clr: got %b want 0", hps_if.ioctl_upload_req); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL active_busy: got %b want 1", busy); end
    endtask

    task automatic test_read_latency;
        issue_rd(25'h00123);
        exp_bc++;
        @(negedge clk_sys);
        n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 17'h00123) begin n_bad++; $display("FAIL lat_n1: mem_rd=%b addr=%h want 1/00123", mem_rd, mem_addr); end
        n_cmp++; if (byte_count !== exp_bc[16:0]) begin n_bad++; $display("FAIL lat_bc: got %0d want %0d", byte_count, exp_bc); end
        tick(1);
        @(negedge clk_sys);
        n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL lat_n2: mem_rd=%b want 0", mem_rd); end
        tick(2);
        @(negedge clk_sys);
        n_cmp++; if (hps_if.ioctl_din !== 8'h5A) begin n_bad++; $display("FAIL din_hold: got %h want 5a", hps_if.ioctl_din); end
    endtask

    task automatic test_out_of_range;
        logic [24:0] addrs [4];
        addrs = '{25'h000FFFF, 25'h0010000, 25'h001FFFF, 25'h1000005};
        for (int i = 0; i < 4; i++) begin
            issue_rd(addrs[i]);
            exp_bc++;
            @(negedge clk_sys);
            n_cmp++; if (mem_rd !== (addrs[i] < 25'd65536)) begin n_bad++; $display("FAIL oor_mem_rd: addr %h mem_rd=%b", addrs[i], mem_rd); end
            n_cmp++; if (byte_count !== exp_bc[16:0]) begin n_bad++; $display("FAIL oor_bc: got %0d want %0d", byte_count, exp_bc); end
            tick(1);
        end
        tick(1);
    endtask

    task automatic test_overrun;
        @(negedge clk_sys);
        n_cmp++; if (overrun_err !== 1'b0) begin n_bad++; $display("FAIL ovr_pre: got %b want 0", overrun_err); end
        issue_rd(25'h00200);
        exp_bc++;
        hps_if.ioctl_rd   = 1'b1;
        hps_if.ioctl_addr = 25'h00300;
        tick(1);
        hps_if.ioctl_rd = 1'b0;
        @(negedge clk_sys);
        n_cmp++; if (overrun_err !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", overrun_err); end
        n_cmp++; if (byte_count !== exp_bc[16:0]) begin n_bad++; $display("FAIL ovr_bc: got %0d want %0d", byte_count, exp_bc); end
        n_cmp++; if (mem_rd !== 1'b0 || mem_addr !== 17'h00200) begin n_bad++; $display("FAIL ovr_fetch: mem_rd=%b addr=%h want 0/00200", mem_rd, mem_addr); end
        tick(2);
    endtask

    task automatic test_upload_end;
        exp_t       e;
        int         done_cnt;
        logic [7:0] din_at_done;
        done_cnt    = 0;
        din_at_done = 8'h00;
        tick(1);
        hps_if.ioctl_rd     = 1'b1;
        hps_if.ioctl_addr   = 25'h0FFF0;
        hps_if.ioctl_upload = 1'b0;
        e.due  = cyc + 3;
        e.data = ref_byte(25'h0FFF0);
        sb_q.push_back(e);
        exp_bc++;
        tick(1);
        hps_if.ioctl_rd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (done === 1'b1) begin
                if (done_cnt == 0) din_at_done = hps_if.ioctl_din;
                done_cnt++;
            end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL end_done: %0d done cycles want 1", done_cnt); end
        n_cmp++; if (din_at_done !== e.data) begin n_bad++; $display("FAIL end_din: got %h want %h", din_at_done, e.data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL end_idle: busy=%b want 0", busy); end
        n_cmp++; if (byte_count !== exp_bc[16:0]) begin n_bad++; $display("FAIL end_bc: got %0d want %0d", byte_count, exp_bc); end
    endtask

    task automatic test_timeout;
        tick(1);
        save_trigger = 1'b1;
        tick(1);
        save_trigger = 1'b0;
        tick(99);
        @(negedge clk_sys);
        n_cmp++; if (hps_if.ioctl_upload_req !== 1'b1 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_early: req=%b err=%b want 1/0", hps_if.ioctl_upload_req, timeout_err); end
        tick(1);
        @(negedge clk_sys);
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
        n_cmp++; if (hps_if.ioctl_upload_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: req=%b busy=%b want 0/0", hps_if.ioctl_upload_req, busy); end
        tick(3);
        @(negedge clk_sys);
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_index_abort;
        hps_if.ioctl_index  = 8'd3;
        hps_if.ioctl_upload = 1'b1;
        save_trigger        = 1'b1;
        tick(1);
        save_trigger = 1'b0;
        @(negedge clk_sys);
        n_cmp++; if (busy !== 1'b0 || hps_if.ioctl_upload_req !== 1'b0) begin n_bad++; $display("FAIL save_ignored: busy=%b req=%b want 0/0", busy, hps_if.ioctl_upload_req); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL save_ign_tmo: got %b want 1", timeout_err); end
        hps_if.ioctl_index = 8'd4;
        tick(1);
        exp_bc = 0;
        @(negedge clk_sys);
        n_cmp++; if (busy !== 1'b1 || byte_count !== 17'd0) begin n_bad++; $display("FAIL hps_entry: busy=%b bc=%0d want 1/0", busy, byte_count); end
        hps_if.ioctl_index = 8'd3;
        tick(1);
        @(negedge clk_sys);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort: busy=%b done=%b want 0/0", busy, done); end
        tick(1);
        @(negedge clk_sys);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
        hps_if.ioctl_upload = 1'b0;
        hps_if.ioctl_index  = 8'd4;
    endtask

    task automatic test_reset_mid;
        int done_cnt;
        done_cnt = 0;
        tick(1);
        save_trigger = 1'b1;
        tick(1);
        save_trigger = 1'b0;
        @(negedge clk_sys);
        n_cmp++; if (timeout_err !== 1'b0 || hps_if.ioctl_upload_req !== 1'b1) begin n_bad++; $display("FAIL tmo_clear: err=%b req=%b want 0/1", timeout_err, hps_if.ioctl_upload_req); end
        hps_if.ioctl_upload = 1'b1;
        tick(1);
        issue_rd(25'h00123);
        reset = 1'b1;
        sb_q.delete();
        tick(1);
        @(negedge clk_sys);
        n_cmp++; if ({mem_rd, busy, done, hps_if.ioctl_upload_req} !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_ctrl: mem_rd/busy/done/req=%b want 0000", {mem_rd, busy, done, hps_if.ioctl_upload_req}); end
        n_cmp++; if (hps_if.ioctl_din !== 8'h00 || byte_count !== 17'd0) begin n_bad++; $display("FAIL rst_mid_data: din=%h bc=%0d want 00/0", hps_if.ioctl_din, byte_count); end
        reset = 1'b0;
        tick(1);
        exp_bc = 0;
        for (int i = 0; i < 256; i++) begin
            issue_rd(25'(i));
            exp_bc++;
            tick(1);
        end
        hps_if.ioctl_upload = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (done === 1'b1) done_cnt++;
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL seq_done: %0d done cycles want 1", done_cnt); end
        n_cmp++; if (byte_count !== 17'd256) begin n_bad++; $display("FAIL seq_bc: got %0d want 256", byte_count); end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) ram[i] = 8'(i) ^ 8'h3C;
        ram[17'h00123] = 8'h5A;
        ram[17'h00200] = 8'hA7;
        ram[17'h00005] = 8'h11;
        ram[17'h0FFFF] = 8'hC3;
        reset               = 1'b1;
        save_trigger        = 1'b0;
        hps_if.ioctl_upload = 1'b0;
        hps_if.ioctl_index  = 8'd0;
        hps_if.ioctl_rd     = 1'b0;
        hps_if.ioctl_addr   = 25'd0;

        test_reset();
        test_core_request();
        test_read_latency();
        test_out_of_range();
        test_overrun();
        test_upload_end();
        test_timeout();
        test_index_abort();
        test_reset_mid();

        tick(4);
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: %0d entries left want 0", sb_q.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
